pwm: RTL and testbench

// - Single-channel, glitch-free PWM generator driven by an 8-bit duty command from the MCU interface.
// - Produces a fixed-frequency pulse train whose high time is proportional to cmd.
// - cmd=0 gives constant low; cmd=255 gives constant high.
// - Sits between the MCU-fed command register and an FPGA output pin.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_prescaler.sv | 37 +++
 rtl/pwm.sv | 74 +++++++
 tb/tb_pwm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module : pwm_pkg
//  Brief  : Shared helper for sizing the PWM prescaler counter.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    // A prescale of 1 still needs a one-bit counter to stay a legal vector.
    function automatic int pre_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// ============================================================================
//  Module : pwm_prescaler
//  Brief  : Free-running 0..PRESCALE-1 divider emitting a one-clock tick.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               PRE_W  = pre_width(PRESCALE);
    localparam logic [PRE_W-1:0] c_last = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (r_pre_cnt == c_last) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    assign tick = (r_pre_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/pwm.sv
// ============================================================================
//  Module : pwm
//  Brief  : Glitch-free single-channel PWM; duty shadowed at period boundary.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cmd,
    output logic             pwm_out
);

    // Counter stops one short of all-ones so a full-scale duty is constant high.
    localparam logic [WIDTH-1:0] c_max = {{(WIDTH-1){1'b1}}, 1'b0};

    logic             w_tick;
    logic             w_boundary;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cmd_q;
    logic [WIDTH-1:0] r_duty_q;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_boundary = w_tick && (r_cnt == c_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_q <= '0;
        end else begin
            r_cmd_q <= cmd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_boundary) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Duty only moves at the wrap, so a period is never partially updated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_q <= '0;
        end else if (w_boundary) begin
            r_duty_q <= r_cmd_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (r_cnt < r_duty_q);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm.sv
// ============================================================================
//  Module : tb_pwm
//  Brief  : Checks two PWM instances (PRESCALE 8 and 1) against a period model.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm;

    logic       clk;
    logic       rst;
    logic [7:0] cmd8;
    logic [7:0] cmd1;
    logic       out8;
    logic       out1;

    pwm #(.WIDTH(8), .PRESCALE(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd8),
        .pwm_out (out8)
    );

    pwm #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd1),
        .pwm_out (out1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: k = clock edges since reset release.
    int k;
    int per[2]  = '{2040, 255};
    int pres[2] = '{8, 1};
    int pending[2];
    int active[2];
    int hi_cnt[2];
    int falls;
    logic prev8;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 2; i++) begin
            pending[i] = 0;
            active[i]  = 0;
            hi_cnt[i]  = 0;
        end
        prev8 = 1'b0;
    endtask

    task automatic cycle();
        int c[2];
        int obs[2];
        int exp;
        c[0] = int'(cmd8);
        c[1] = int'(cmd1);
        @(posedge clk);
        #1;
        k++;
        obs[0] = int'(out8);
        obs[1] = int'(out1);
        for (int i = 0; i < 2; i++) begin
            // A period's duty is the command present one clock before the wrap edge.
            if (((k - 1) % per[i] == 0) && (k > 1)) active[i] = pending[i];
            if (k % per[i] == per[i] - 1) pending[i] = c[i];
            exp = ((((k - 1) % per[i]) / pres[i]) < active[i]) ? 1 : 0;
            chk((i == 0) ? "out_p8" : "out_p1", obs[i], exp);
            hi_cnt[i] += obs[i];
            if (k % per[i] == 0) begin
                chk((i == 0) ? "high_per_period_p8" : "high_per_period_p1",
                    hi_cnt[i], active[i] * pres[i]);
                hi_cnt[i] = 0;
            end
        end
        if (prev8 && !out8) falls++;
        prev8 = out8;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst  = 1'b1;
        cmd8 = 8'd0;
        cmd1 = 8'd0;
        falls = 0;
        model_reset();

        repeat (5) begin
            @(posedge clk);
            #1;
            chk("reset_out_p8", int'(out8), 0);
            chk("reset_out_p1", int'(out1), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // First period after release must stay low even with a command pending.
        cmd1 = 8'd1;
        run(2040);
        chk("first_period_pending_p8", pending[0], 0);

        cmd8 = 8'd100;
        run(4 * 2040);
        cmd8 = 8'd50;
        run(2 * 2040);
        cmd8 = 8'd200;
        run(2 * 2040);

        // Command changes on the very edge that wraps the period.
        while (k % 2040 != 2039) cycle();
        cmd8 = 8'd30;
        run(2 * 2040);

        cmd8 = 8'd255;
        run(2040);
        falls = 0;
        prev8 = out8;
        run(3 * 2040);
        chk("full_scale_falling_edges", falls, 0);
        chk("full_scale_level", int'(out8), 1);

        cmd8 = 8'd0;
        run(2 * 2040);

        repeat (6) begin
            run(int'($urandom_range(100, 3000)));
            cmd8 = 8'($urandom);
            cmd1 = 8'($urandom_range(0, 255));
        end
        run(2040);

        // Reset pulse while the output is high.
        cmd8 = 8'd200;
        cmd1 = 8'd1;
        run(2 * 2040);
        while (k % 2040 != 500) cycle();
        chk("pre_reset_high_p8", int'(out8), 1);
        #4;
        rst = 1'b1;
        #1;
        chk("async_reset_p8", int'(out8), 0);
        chk("async_reset_p1", int'(out1), 0);
        @(posedge clk);
        #1;
        chk("held_reset_p8", int'(out8), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(3 * 2040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
